// File: rtl/seq_det_pat_mealy_if.sv
// Serial stream, pattern-load and status bundle for the Mealy pattern detector.
// The master drives the stream and controls, and the slave (the detector) returns match status.
interface seq_det_pat_mealy_if #(
  parameter int PAT_LEN = 4,
  parameter int CNT_W   = 8
);
  logic               in;
  logic               in_valid;
  logic               overlap;
  logic               pat_load;
  logic [PAT_LEN-1:0] pat_in;
  logic               clr_cnt;
  logic               z;
  logic               z_q;
  logic [CNT_W-1:0]   match_cnt;
  logic               cnt_sat;

  modport master (
    output in, in_valid, overlap, pat_load, pat_in, clr_cnt,
    input  z, z_q, match_cnt, cnt_sat
  );

  modport slave (
    input  in, in_valid, overlap, pat_load, pat_in, clr_cnt,
    output z, z_q, match_cnt, cnt_sat
  );
endinterface

// File: rtl/seq_det_pat_mealy.sv
// Mealy detector for a runtime-loadable PAT_LEN-bit serial pattern, with overlapping or
// non-overlapping detection and a saturating match counter.
module seq_det_pat_mealy #(
  parameter int                 PAT_LEN = 4,
  parameter int                 CNT_W   = 8,
  parameter logic [PAT_LEN-1:0] PAT_RST = {PAT_LEN{1'b1}}
) (
  input logic                clk,
  input logic                rst,
  seq_det_pat_mealy_if.slave bus
);

  localparam int                FILL_W    = $clog2(PAT_LEN);
  localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(PAT_LEN - 1);

  typedef enum logic [1:0] {
    EMPTY,
    FILLING,
    ARMED
  } state_t;

  state_t             state;
  logic [PAT_LEN-1:0] pat;
  logic [PAT_LEN-2:0] hist;
  logic [FILL_W-1:0]  fill;
  logic [FILL_W-1:0]  fill_inc;
  logic [PAT_LEN-1:0] window;
  logic               match;
  logic [CNT_W-1:0]   match_cnt;
  logic               cnt_sat;
  logic               z_q;

  // The state is kept alongside fill so that ARMED can be tested without a wide compare.
  function automatic state_t state_of(input logic [FILL_W-1:0] f);
    if (f == '0)
      return EMPTY;
    else if (f == FILL_FULL)
      return ARMED;
    else
      return FILLING;
  endfunction

  assign window   = {hist, bus.in};
  assign fill_inc = (fill == FILL_FULL) ? fill : fill + FILL_W'(1);
  assign match    = ~rst & bus.in_valid & ~bus.pat_load & (state == ARMED) & (window == pat);
  assign cnt_sat  = &match_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pat       <= PAT_RST;
      hist      <= '0;
      fill      <= '0;
      state     <= EMPTY;
      match_cnt <= '0;
      z_q       <= 1'b0;
    end else begin
      z_q <= match;

      // A clear that coincides with a match leaves that match counted.
      if (bus.clr_cnt)
        match_cnt <= match ? CNT_W'(1) : '0;
      else if (match && !cnt_sat)
        match_cnt <= match_cnt + CNT_W'(1);

      if (bus.pat_load) begin
        pat   <= bus.pat_in;
        hist  <= '0;
        fill  <= '0;
        state <= EMPTY;
      end else if (bus.in_valid) begin
        if (match && !bus.overlap) begin
          hist  <= '0;
          fill  <= '0;
          state <= EMPTY;
        end else begin
          hist  <= window[PAT_LEN-2:0];
          fill  <= fill_inc;
          state <= state_of(fill_inc);
        end
      end
    end
  end

  assign bus.z         = match;
  assign bus.z_q       = z_q;
  assign bus.match_cnt = match_cnt;
  assign bus.cnt_sat   = cnt_sat;

endmodule
